// File: rtl/ptp_sched_pkg.sv
// ptp_tx_sched shared types: message codes, priority order,
// FSM states and the gPTP master role code.
package ptp_sched_pkg;

  localparam int NUM_TYPES = 6;

  typedef enum logic [2:0] {
    MSG_SYNC           = 3'd0,
    MSG_FOLLOW_UP      = 3'd1,
    MSG_PDELAY_REQ     = 3'd2,
    MSG_PDELAY_RESP    = 3'd3,
    MSG_PDELAY_RESP_FU = 3'd4,
    MSG_ANNOUNCE       = 3'd5
  } msg_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  localparam logic [2:0] ROLE_MASTER = 3'b000;

  // SYNC, FOLLOW_UP and ANNOUNCE only make sense as master
  localparam logic [5:0] MASTER_ONLY = 6'b100011;

  // Highest priority first
  localparam msg_t PRIO [NUM_TYPES] = '{
    MSG_PDELAY_RESP,
    MSG_PDELAY_RESP_FU,
    MSG_FOLLOW_UP,
    MSG_SYNC,
    MSG_PDELAY_REQ,
    MSG_ANNOUNCE
  };

  // Walk from lowest to highest so the last hit wins
  function automatic logic [2:0] prio_pick(
    input logic [5:0] pend
  );
    logic [2:0] w;
    w = MSG_SYNC;
    for (int i = NUM_TYPES - 1; i >= 0; i--) begin
      if (pend[PRIO[i]]) w = PRIO[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/ptp_interval_timer.sv
// Periodic interval timer: counts 0..interval-1, pulses expire at the top.
// Ports: clk, rst (async high), run, interval (0 = off), expire.
module ptp_interval_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [W-1:0] interval,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         live;

  // >= so a shrunk interval wraps at once instead of running to 2^W
  always_comb begin
    live    = run && (interval != '0);
    expire  = live && (count_q >= interval - 1'b1);
    count_d = count_q + 1'b1;
    if (!live || expire) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/ptp_tx_sched.sv
// gPTP per-port transmit scheduler: timers + pending set + priority FSM
// onto the frame generator req/ack/done. Optional PTP_TX_SCHED_WDOG_EN.
module ptp_tx_sched
  import ptp_sched_pkg::*;
#(
  parameter int INTERVAL_WIDTH = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TX_TIMEOUT     = 25000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic [2:0]                i_ptp_bcm_state,
  input  logic                      i_twostep,
  input  logic [INTERVAL_WIDTH-1:0] i_sync_interval,
  input  logic [INTERVAL_WIDTH-1:0] i_announce_interval,
  input  logic [INTERVAL_WIDTH-1:0] i_pdelay_interval,
  input  logic                      i_pdelay_resp_req,
  output logic                      o_tx_req,
  output logic [2:0]                o_tx_type,
  input  logic                      i_tx_ack,
  input  logic                      i_tx_done,
  output logic                      o_sync_event_start,
  output logic                      o_pdelay_event_start,
  output logic                      o_pdelay_event_resp_start,
  output logic                      o_tx_busy,
  output logic                      o_tx_timeout,
  output logic [CNT_WIDTH-1:0]      o_overrun_cnt
);

`ifdef PTP_TX_SCHED_WDOG_EN
  localparam logic WDOG_ON = 1'b1;
`else
  localparam logic WDOG_ON = 1'b0;
`endif

  localparam int WDW = $clog2(TX_TIMEOUT + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TX_TIMEOUT - 1);

  logic master;
  logic exp_sync;
  logic exp_ann;
  logic exp_pdly;

  state_t         state_q, state_d;
  logic [2:0]     type_q, type_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           tmo_q, tmo_d;
  logic [5:0]     pend_q, pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [5:0]     set;
  logic [5:0]     clr;
  logic [5:0]     flush;
  logic [5:0]     ovr;
  logic [5:0]     avail;
  logic [2:0]     win;
  logic [2:0]     inc;
  logic [CNT_WIDTH:0] sum;
  logic           grant;

  assign master = (i_ptp_bcm_state == ROLE_MASTER);

  ptp_interval_timer #(.W(INTERVAL_WIDTH)) u_sync_tmr (
    .clk      (i_clk),
    .rst      (i_rst),
    .run      (i_enable && master),
    .interval (i_sync_interval),
    .expire   (exp_sync)
  );

  ptp_interval_timer #(.W(INTERVAL_WIDTH)) u_ann_tmr (
    .clk      (i_clk),
    .rst      (i_rst),
    .run      (i_enable && master),
    .interval (i_announce_interval),
    .expire   (exp_ann)
  );

  ptp_interval_timer #(.W(INTERVAL_WIDTH)) u_pdly_tmr (
    .clk      (i_clk),
    .rst      (i_rst),
    .run      (i_enable),
    .interval (i_pdelay_interval),
    .expire   (exp_pdly)
  );

  // Pending set/clear, flush and overrun accounting
  always_comb begin
    set = '0;
    set[MSG_SYNC]        = exp_sync;
    set[MSG_ANNOUNCE]    = exp_ann;
    set[MSG_PDELAY_REQ]  = exp_pdly;
    set[MSG_PDELAY_RESP] = i_pdelay_resp_req;
    if (state_q == ST_WAIT_DONE && i_tx_done && i_twostep) begin
      if (type_q == MSG_SYNC && master)
        set[MSG_FOLLOW_UP] = 1'b1;
      if (type_q == MSG_PDELAY_RESP)
        set[MSG_PDELAY_RESP_FU] = 1'b1;
    end
    clr = '0;
    if (state_q == ST_REQ && i_tx_ack) clr[type_q] = 1'b1;
    flush = !i_enable ? '1 : (master ? '0 : MASTER_ONLY);
    // A set landing on its own ack clear is a fresh request, not a loss
    ovr    = set & pend_q & ~clr & ~flush;
    pend_d = ((pend_q & ~clr) | set) & ~flush;
    avail  = pend_q & ~flush;
    win    = prio_pick(avail);
    inc    = '0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      inc = inc + {2'b00, ovr[i]};
    end
    sum   = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(inc);
    cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      type_q  <= '0;
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    wdog_d  = '0;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|avail) begin
          state_d = ST_REQ;
          type_d  = win;
        end
      end
      ST_REQ: begin
        if (i_tx_ack) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wdog_d = wdog_q + 1'b1;
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end else if (WDOG_ON && wdog_q == WDOG_LAST) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    grant                     = (state_q == ST_IDLE) && (|avail);
    o_tx_req                  = (state_q == ST_REQ);
    o_tx_busy                 = (state_q != ST_IDLE);
    o_tx_type                 = type_q;
    o_tx_timeout              = tmo_q;
    o_overrun_cnt             = cnt_q;
    o_sync_event_start        = grant && (win == MSG_SYNC);
    o_pdelay_event_start      = grant && (win == MSG_PDELAY_REQ);
    o_pdelay_event_resp_start = grant && (win == MSG_PDELAY_RESP);
  end

endmodule

// File: tb/tb_ptp_tx_sched.sv
// Self-checking bench for ptp_tx_sched; directed steps, random timing.
// Watchdog section follows PTP_TX_SCHED_WDOG_EN.
module tb_ptp_tx_sched;

  localparam int TB_TO = 300;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic [2:0]  i_ptp_bcm_state = 3'b000;
  logic        i_twostep = 1'b0;
  logic [31:0] i_sync_interval = '0;
  logic [31:0] i_announce_interval = '0;
  logic [31:0] i_pdelay_interval = '0;
  logic        i_pdelay_resp_req = 1'b0;
  logic        i_tx_ack = 1'b0;
  logic        i_tx_done = 1'b0;
  logic        o_tx_req;
  logic [2:0]  o_tx_type;
  logic        o_sync_event_start;
  logic        o_pdelay_event_start;
  logic        o_pdelay_event_resp_start;
  logic        o_tx_busy;
  logic        o_tx_timeout;
  logic [15:0] o_overrun_cnt;

  ptp_tx_sched #(
    .INTERVAL_WIDTH (32),
    .CNT_WIDTH      (16),
    .TX_TIMEOUT     (TB_TO)
  ) dut (
    .i_clk                     (clk),
    .i_rst                     (i_rst),
    .i_enable                  (i_enable),
    .i_ptp_bcm_state           (i_ptp_bcm_state),
    .i_twostep                 (i_twostep),
    .i_sync_interval           (i_sync_interval),
    .i_announce_interval       (i_announce_interval),
    .i_pdelay_interval         (i_pdelay_interval),
    .i_pdelay_resp_req         (i_pdelay_resp_req),
    .o_tx_req                  (o_tx_req),
    .o_tx_type                 (o_tx_type),
    .i_tx_ack                  (i_tx_ack),
    .i_tx_done                 (i_tx_done),
    .o_sync_event_start        (o_sync_event_start),
    .o_pdelay_event_start      (o_pdelay_event_start),
    .o_pdelay_event_resp_start (o_pdelay_event_resp_start),
    .o_tx_busy                 (o_tx_busy),
    .o_tx_timeout              (o_tx_timeout),
    .o_overrun_cnt             (o_overrun_cnt)
  );

  always #2 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_start(
    input logic [2:0] t
  );
    case (t)
      3'd0:    return 3'b001;
      3'd2:    return 3'b010;
      3'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Grant log: a grant is a rising o_tx_req; the start pulse for
  // that type must have appeared on the cycle just before it.
  int         gtype[$];
  int         gcyc[$];
  logic       prev_req = 1'b0;
  logic [2:0] prev_start = '0;

  initial forever begin
    @(posedge clk);
    #1;
    if (o_tx_req && !prev_req) begin
      gtype.push_back(int'(o_tx_type));
      gcyc.push_back(cyc);
      chk("start_pulse", 32'(prev_start),
          32'(exp_start(o_tx_type)));
    end
    prev_req   = o_tx_req;
    prev_start = {o_pdelay_event_resp_start,
                  o_pdelay_event_start,
                  o_sync_event_start};
  end

  // Frame generator model
  bit resp_on  = 1'b0;
  int ack_dly  = 2;
  int done_dly = 10;

  initial forever begin
    @(negedge clk);
    if (resp_on && o_tx_req && !i_rst) begin
      repeat (ack_dly) @(negedge clk);
      i_tx_ack = 1'b1;
      @(negedge clk);
      i_tx_ack = 1'b0;
      repeat (done_dly) @(negedge clk);
      i_tx_done = 1'b1;
      @(negedge clk);
      i_tx_done = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

  task automatic do_reset();
    resp_on  = 1'b0;
    i_enable = 1'b0;
    repeat (40) @(negedge clk);
    i_rst = 1'b1;
    i_twostep = 1'b0;
    i_ptp_bcm_state = 3'b000;
    i_sync_interval = '0;
    i_announce_interval = '0;
    i_pdelay_interval = '0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_run(output int c0);
    gtype.delete();
    gcyc.delete();
    i_enable = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_grants(input string tag,
                             input int n,
                             input int budget);
    int k;
    k = 0;
    while (gtype.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_grants"}, gtype.size(), n);
  endtask

  task automatic check_types(input string tag,
                             input int exp [4],
                             input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_type%0d", tag, i), gtype[i], exp[i]);
  endtask

  initial begin
    int c0;
    int iv;
    int bad;
    int n;
    int ord [4];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", o_tx_req, 0);
    chk("rst_busy", o_tx_busy, 0);
    chk("rst_type", o_tx_type, 0);
    chk("rst_ovr", o_overrun_cnt, 0);
    chk("rst_tmo", o_tx_timeout, 0);
    chk("rst_start", {o_sync_event_start,
        o_pdelay_event_start,
        o_pdelay_event_resp_start}, 0);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", o_tx_busy, 0);

    // Periodic SYNC, interval 100
    ack_dly = 2;
    done_dly = 10;
    resp_on = 1'b1;
    i_sync_interval = 100;
    start_run(c0);
    wait_grants("t1", 4, 500);
    chk("t1_first", gcyc[0] - c0, 101);
    for (int i = 0; i < 4; i++)
      chk("t1_type", gtype[i], 0);
    for (int i = 1; i < 4; i++)
      chk("t1_gap", gcyc[i] - gcyc[i-1], 100);
    chk("t1_ovr", o_overrun_cnt, 0);

    // Interval shrunk below the running count
    do_reset();
    resp_on = 1'b1;
    i_sync_interval = 100;
    start_run(c0);
    repeat (60) @(negedge clk);
    i_sync_interval = 20;
    wait_grants("shr", 2, 100);
    chk("shr_first", gcyc[0] - c0, 62);
    chk("shr_gap", gcyc[1] - gcyc[0], 20);

    // Random intervals and handshake timing
    for (int r = 0; r < 3; r++) begin
      do_reset();
      iv = $urandom_range(120, 40);
      ack_dly = $urandom_range(3, 0);
      done_dly = $urandom_range(15, 1);
      resp_on = 1'b1;
      i_sync_interval = iv;
      start_run(c0);
      wait_grants("rnd", 3, 4 * iv + 50);
      chk("rnd_first", gcyc[0] - c0, iv + 1);
      chk("rnd_gap1", gcyc[1] - gcyc[0], iv);
      chk("rnd_gap2", gcyc[2] - gcyc[1], iv);
      chk("rnd_ovr", o_overrun_cnt, 0);
    end

    // Two-step: FOLLOW_UP ahead of ANNOUNCE, RESP then RESP_FU
    do_reset();
    i_twostep = 1'b1;
    ack_dly = 1;
    done_dly = 4;
    resp_on = 1'b1;
    i_sync_interval = 60;
    i_announce_interval = 60;
    start_run(c0);
    wait_grants("ts", 3, 200);
    i_sync_interval = '0;
    i_announce_interval = '0;
    ord = '{0, 1, 5, 0};
    check_types("ts", ord, 3);
    repeat (30) @(negedge clk);
    gtype.delete();
    gcyc.delete();
    i_pdelay_resp_req = 1'b1;
    @(negedge clk);
    i_pdelay_resp_req = 1'b0;
    wait_grants("pr", 2, 100);
    ord = '{3, 4, 0, 0};
    check_types("pr", ord, 2);

    // Four requests set on the same cycle
    do_reset();
    ack_dly = 1;
    done_dly = 3;
    resp_on = 1'b1;
    i_sync_interval = 80;
    i_announce_interval = 80;
    i_pdelay_interval = 80;
    start_run(c0);
    repeat (79) @(negedge clk);
    i_pdelay_resp_req = 1'b1;
    @(negedge clk);
    i_pdelay_resp_req = 1'b0;
    wait_grants("sim", 4, 200);
    chk("sim_first", gcyc[0] - c0, 81);
    ord = '{3, 0, 2, 5};
    check_types("sim", ord, 4);
    chk("sim_ovr", o_overrun_cnt, 0);

    // Ack withheld for 250 cycles
    do_reset();
    i_sync_interval = 100;
    start_run(c0);
    wait_grants("hold", 1, 200);
    bad = 0;
    repeat (250) begin
      @(negedge clk);
      if (!o_tx_req || o_tx_type !== 3'd0) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_ovr", o_overrun_cnt, 2);
    i_tx_ack = 1'b1;
    @(negedge clk);
    i_tx_ack = 1'b0;
    chk("hold_req_drop", o_tx_req, 0);
    chk("hold_busy", o_tx_busy, 1);
    repeat (3) @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_cleared", gtype.size(), 1);
    chk("hold_ovr2", o_overrun_cnt, 2);

    // Master -> slave with SYNC in flight
    do_reset();
    i_twostep = 1'b1;
    i_sync_interval = 50;
    i_announce_interval = 50;
    start_run(c0);
    wait_grants("role", 1, 100);
    chk("role_t0", gtype[0], 0);
    i_tx_ack = 1'b1;
    @(negedge clk);
    i_tx_ack = 1'b0;
    repeat (55) @(negedge clk);
    i_ptp_bcm_state = 3'b001;
    i_pdelay_interval = 40;
    gtype.delete();
    gcyc.delete();
    repeat (5) @(negedge clk);
    chk("role_inflight", o_tx_busy, 1);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    ack_dly = 1;
    done_dly = 3;
    resp_on = 1'b1;
    repeat (190) @(negedge clk);
    chk("role_ngrant", gtype.size(), 4);
    bad = 0;
    foreach (gtype[i]) if (gtype[i] != 2) bad++;
    chk("role_only_pdly", bad, 0);
    chk("role_ovr", o_overrun_cnt, 1);

    // Watchdog / stuck WAIT_DONE, then reset mid-transaction
    do_reset();
    i_twostep = 1'b1;
    i_sync_interval = 30;
    start_run(c0);
    wait_grants("wd", 1, 100);
    i_tx_ack = 1'b1;
    @(negedge clk);
    i_tx_ack = 1'b0;
`ifdef PTP_TX_SCHED_WDOG_EN
    n = 0;
    while (!o_tx_timeout && n < TB_TO + 50) begin
      @(negedge clk);
      n++;
    end
    gtype.delete();
    gcyc.delete();
    chk("wd_cycles", n, TB_TO);
    chk("wd_idle", o_tx_busy, 0);
    @(negedge clk);
    chk("wd_pulse", o_tx_timeout, 0);
    wait_grants("wd_next", 1, 20);
    chk("wd_no_fu", gtype[0], 0);
    i_tx_ack = 1'b1;
    @(negedge clk);
    i_tx_ack = 1'b0;
`else
    n = 0;
    repeat (TB_TO + 50) begin
      @(negedge clk);
      if (o_tx_timeout) n++;
    end
    chk("nowd_tmo", n, 0);
`endif
    @(negedge clk);
    chk("mid_busy", o_tx_busy, 1);
    i_rst = 1'b1;
    #1;
    chk("mid_req", o_tx_req, 0);
    chk("mid_busy0", o_tx_busy, 0);
    chk("mid_type", o_tx_type, 0);
    chk("mid_ovr", o_overrun_cnt, 0);
    chk("mid_tmo", o_tx_timeout, 0);
    chk("mid_start", {o_sync_event_start,
        o_pdelay_event_start,
        o_pdelay_event_resp_start}, 0);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    i_enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/ptp_tx_sched.md
Name: ptp_tx_sched

Overview:
Transmit scheduler for gPTP messages on one port. Three interval timers generate periodic SYNC, ANNOUNCE and PDELAY_REQ requests. Externally requested PDELAY_RESP and two-step follow-ups are added to these. All requests are arbitrated by fixed priority onto the single frame-generator request/ack/done handshake, and each grant is reported as a start pulse to the PTP state machine. The block sits between the PTP FSM/BMCA status and the PTP frame generator.

Parameters:
INTERVAL_WIDTH, 32, width of interval/timer counters (units: i_clk cycles)
CNT_WIDTH, 16, width of saturating overrun counter
TX_TIMEOUT, 25000, WAIT_DONE watchdog limit in cycles (100 us at 250 MHz)

Ports:
i_clk  in  1  250 MHz clock
i_rst  in  1  asynchronous reset, active-high
i_enable  in  1  scheduler enable; low = flush all pending and stop timers
i_ptp_bcm_state  in  3  000 master, 001 slave, others reserved (treated as slave)
i_twostep  in  1  1 = two-step; schedule FOLLOW_UP / PDELAY_RESP_FU after parent
i_sync_interval  in  INTERVAL_WIDTH  sync period in cycles; 0 disables
i_announce_interval  in  INTERVAL_WIDTH  announce period; 0 disables
i_pdelay_interval  in  INTERVAL_WIDTH  pdelay_req period; 0 disables
i_pdelay_resp_req  in  1  pulse: pdelay_req received, response needed
o_tx_req  out  1  request to frame generator
o_tx_type  out  3  0 SYNC,1 FOLLOW_UP,2 PDELAY_REQ,3 PDELAY_RESP,4 PDELAY_RESP_FU,5 ANNOUNCE
i_tx_ack  in  1  frame generator accepted request
i_tx_done  in  1  pulse: frame fully sent (timestamp captured)
o_sync_event_start  out  1  1-cycle pulse on SYNC grant
o_pdelay_event_start  out  1  1-cycle pulse on PDELAY_REQ grant
o_pdelay_event_resp_start  out  1  1-cycle pulse on PDELAY_RESP grant
o_tx_busy  out  1  high in REQ or WAIT_DONE
o_tx_timeout  out  1  1-cycle pulse on watchdog expiry
o_overrun_cnt  out  CNT_WIDTH  saturating count of requests lost because the same type was already pending

Behaviour:
- Reset: all outputs 0, state IDLE, timers 0, pending vector 0.
- Timers: count 0..interval-1; at interval-1 set pending[type] and restart at 0. Interval 0 or i_enable=0 holds the timer at 0. SYNC and ANNOUNCE timers run only when i_ptp_bcm_state==000; otherwise they are held at 0. The PDELAY timer runs in any role.
- Pending vector has 6 bits, one per type. Setting a bit that is already set increments o_overrun_cnt, saturating at all-ones. i_pdelay_resp_req sets pending[3].
- Priority, high to low: PDELAY_RESP, PDELAY_RESP_FU, FOLLOW_UP, SYNC, PDELAY_REQ, ANNOUNCE.
- FSM:
  - IDLE: if any pending bit is set, latch the winner into o_tx_type, assert o_tx_req next cycle, go to REQ. Emit the start pulse for the type in that same cycle.
  - REQ: o_tx_req held high and o_tx_type held stable until i_tx_ack. On i_tx_ack: drop o_tx_req next cycle, clear pending[type], go to WAIT_DONE.
  - WAIT_DONE: on i_tx_done go to IDLE. If i_twostep=1, SYNC sets pending[1] and PDELAY_RESP sets pending[4] in that same cycle.
- Grant-to-req latency is 1 cycle. Back-to-back grants take at least one IDLE cycle.
- Simultaneous set of a pending bit and its clear on ack: the set wins and the bit stays pending; no overrun is counted.
- Leaving master (state != 000): clear pending[0], pending[1] and pending[5] the same cycle. An in-flight transaction still completes normally, but no follow-up is scheduled if the role is no longer master at i_tx_done.
- i_enable falling: clear all pending bits; an in-flight transaction completes.
- i_tx_done in IDLE or REQ is ignored. i_tx_ack outside REQ is ignored.
- An interval change takes effect at the next wrap. If the timer is already beyond the new interval-1, it wraps to 0 immediately and sets pending.

Optional Feature:
PTP_TX_SCHED_WDOG_EN:
- Defined: WAIT_DONE counts cycles. At TX_TIMEOUT without i_tx_done, pulse o_tx_timeout and return to IDLE with no follow-up scheduled.
- Undefined: WAIT_DONE waits indefinitely and o_tx_timeout is tied to 0.

Decomposition:
- Package ptp_sched_pkg: message type codes (3 bits), priority order, FSM state encoding (IDLE/REQ/WAIT_DONE), role code for master (3'b000).
- Sub-module ptp_interval_timer, instantiated three times. Ports: clk, rst, run, interval, expire pulse.

Test Plan:
- Master, sync_interval=100, ack 2 cycles after req, done 10 cycles later, twostep=0 -> o_tx_type=0 req every 100 cycles, o_sync_event_start pulse per grant, overrun_cnt=0.
- twostep=1, SYNC done -> next grant type 1 (FOLLOW_UP) before any pending ANNOUNCE. i_pdelay_resp_req pulse -> type 3 then type 4.
- Pending SYNC, PDELAY_REQ, ANNOUNCE and PDELAY_RESP set in the same cycle -> grant order 3, 0, 2, 5 (twostep=0).
- Hold i_tx_ack low for 250 cycles with sync_interval=100 -> o_tx_req/o_tx_type stable, o_overrun_cnt increments to 2 while SYNC pending.
- Role 000 -> 001 with pending SYNC/ANNOUNCE and an in-flight SYNC -> pending cleared, in-flight completes, no FOLLOW_UP; PDELAY_REQ continues.
- With PTP_TX_SCHED_WDOG_EN, ack but never done -> o_tx_timeout pulses at TX_TIMEOUT cycles, FSM back in IDLE; assert i_rst mid-WAIT_DONE -> all outputs 0 immediately.
